core_test_seq: RTL

CORE_TEST_SEQ -- requirements
Module: core_test_seq

---
 rtl/core_test_seq.sv | 130 +++++++++++++
 1 files changed

// File: rtl/core_test_seq.sv
// Core test sequencer: holds the core in reset, releases it, watches rd_data_i for a pass/fail word or a timeout.
// Optional macro CORE_TEST_SEQ_CYCLE_COUNT_EN exposes the RUN cycle counter on cycle_count_o.
module core_test_seq #(
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    RESET_CYCLES   = 2,
    parameter int                    TIMEOUT_CYCLES = 200,
    parameter logic [DATA_WIDTH-1:0] PASS_VALUE     = DATA_WIDTH'(32'h0000_0001),
    parameter logic [DATA_WIDTH-1:0] FAIL_VALUE     = DATA_WIDTH'(32'h0000_DEAD),
    parameter int                    NUM_RUNS       = 1
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    // start_i is a one-cycle request with no ready: it is taken only in IDLE or DONE and dropped otherwise.
    input  logic                  start_i,
    input  logic [DATA_WIDTH-1:0] rd_data_i,
    output logic                  core_reset_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  pass_o,
    output logic                  fail_o,
    output logic                  timeout_o,
    output logic [3:0]            run_idx_o,
    output logic [15:0]           cycle_count_o,
    output logic [1:0]            dbg_state_o
);

    typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, RUN = 2'd2, DONE = 2'd3} state_t;

    localparam logic [7:0]  HOLD_LAST    = 8'(RESET_CYCLES - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]  IDX_LAST     = 4'(NUM_RUNS - 1);

    state_t      state_q, state_d;
    logic [7:0]  hold_cnt_q, hold_cnt_d;
    logic [15:0] run_cnt_q, run_cnt_d;
    logic [3:0]  run_idx_d;
    logic        pass_d, fail_d, timeout_d;
    logic        fail_hit, pass_hit;

    assign fail_hit = (rd_data_i == FAIL_VALUE);
    assign pass_hit = (rd_data_i == PASS_VALUE);

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        run_cnt_d  = run_cnt_q;
        run_idx_d  = run_idx_o;
        pass_d     = pass_o;
        fail_d     = fail_o;
        timeout_d  = timeout_o;
        case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    state_d    = HOLD;
                    hold_cnt_d = 8'd0;
                    run_cnt_d  = 16'd0;
                    run_idx_d  = 4'd0;
                    pass_d     = 1'b0;
                    fail_d     = 1'b0;
                    timeout_d  = 1'b0;
                end
            end
            HOLD: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d   = RUN;
                    run_cnt_d = 16'd0;
                end else begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end
            RUN: begin
                if (run_cnt_q != 16'hFFFF) run_cnt_d = run_cnt_q + 16'd1;
                // Fail is checked first so it wins when PASS_VALUE == FAIL_VALUE; any match beats timeout.
                if (fail_hit) begin
                    state_d = DONE;
                    fail_d  = 1'b1;
                end else if (pass_hit) begin
                    if (run_idx_o == IDX_LAST) begin
                        state_d = DONE;
                        pass_d  = 1'b1;
                    end else begin
                        state_d    = HOLD;
                        hold_cnt_d = 8'd0;
                        run_idx_d  = run_idx_o + 4'd1;
                    end
                end else if (run_cnt_q == TIMEOUT_LAST) begin
                    state_d   = DONE;
                    timeout_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            hold_cnt_q   <= 8'd0;
            run_cnt_q    <= 16'd0;
            run_idx_o    <= 4'd0;
            pass_o       <= 1'b0;
            fail_o       <= 1'b0;
            timeout_o    <= 1'b0;
            core_reset_o <= 1'b1;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            run_cnt_q    <= run_cnt_d;
            run_idx_o    <= run_idx_d;
            pass_o       <= pass_d;
            fail_o       <= fail_d;
            timeout_o    <= timeout_d;
            // Status outputs are decoded from the next state so they line up with state_q after the edge.
            core_reset_o <= (state_d != RUN);
            busy_o       <= (state_d == HOLD) || (state_d == RUN);
            done_o       <= (state_d == DONE);
        end
    end

    assign dbg_state_o = state_q;

`ifdef CORE_TEST_SEQ_CYCLE_COUNT_EN
    assign cycle_count_o = run_cnt_q;
`else
    assign cycle_count_o = 16'd0;
`endif

endmodule
